// File: rtl/huffman_pkg.sv
// Shared widths and FIFO entry layout for the Huffman output packer.
package huffman_pkg;

    localparam int SYMBOL_W = 8;
    localparam int WORD_W   = 32;
    localparam int LANES    = 4;
    localparam int ENTRY_W  = WORD_W + LANES + 1;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [LANES-1:0]  keep;
        logic              last;
    } entry_t;

    function automatic logic [LANES-1:0] lane_keep(input logic [1:0] lane);
        logic [LANES-1:0] k;
        k = 4'b0001;
        unique case (lane)
            2'd0: k = 4'b0001;
            2'd1: k = 4'b0011;
            2'd2: k = 4'b0111;
            2'd3: k = 4'b1111;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/huffman_sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is visible whenever not empty.
module huffman_sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_level   = r_wptr - r_rptr;
    assign o_full    = (o_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_wptr == r_rptr);
    // A pop frees the slot in the same cycle, so push is legal when full.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/huffman_symbol_packer.sv
// Packs decoded 8-bit symbols into 32-bit words and streams them out over
// AXI4-Stream with tkeep/tlast for partial final words.
module huffman_symbol_packer
    import huffman_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [7:0]          symbol_in,
    input  logic                symbol_valid,
    input  logic                symbol_last,
    output logic                symbol_ready,
    output logic [31:0]         m_axis_tdata,
    output logic [3:0]          m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [31:0]         byte_count,
    output logic [15:0]         frame_count,
    output logic [FIFO_AW:0]    fifo_level
);

    logic              r_run;
    logic [1:0]        r_lane;
    logic [WORD_W-1:0] r_pack;
    logic [31:0]       r_byte_count;
    logic [15:0]       r_frame_count;

    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_done;
    logic              w_pop;
    logic [WORD_W-1:0] w_word;
    entry_t            w_entry;
    entry_t            w_head;

    // Ready depends only on registered state, never on valid or tready.
    assign symbol_ready = r_run && !w_full;
    assign w_accept     = symbol_valid && symbol_ready;
    assign w_done       = w_accept && (symbol_last || (r_lane == 2'd3));
    assign w_pop        = m_axis_tvalid && m_axis_tready;

    always_comb begin
        w_word = r_pack;
        w_word[{r_lane, 3'b000} +: SYMBOL_W] = symbol_in;
    end

    assign w_entry.data = w_word;
    assign w_entry.keep = lane_keep(r_lane);
    assign w_entry.last = symbol_last;

    huffman_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_done),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = w_head.data;
    assign m_axis_tkeep  = w_head.keep;
    assign m_axis_tlast  = w_head.last;
    assign byte_count    = r_byte_count;
    assign frame_count   = r_frame_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run         <= 1'b0;
            r_lane        <= '0;
            r_pack        <= '0;
            r_byte_count  <= '0;
            r_frame_count <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_accept) begin
                r_byte_count <= r_byte_count + 32'd1;
                if (symbol_last) r_frame_count <= r_frame_count + 16'd1;
                if (w_done) begin
                    r_lane <= '0;
                    r_pack <= '0;
                end else begin
                    r_lane <= r_lane + 2'd1;
                    r_pack <= w_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_huffman_symbol_packer.sv
// Directed and randomised checks of the symbol packer against a word queue.
module tb_huffman_symbol_packer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  symbol_in;
    logic        symbol_valid;
    logic        symbol_last;
    logic        symbol_ready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] byte_count;
    logic [15:0] frame_count;
    logic [AW:0] fifo_level;

    always #5 clock = ~clock;

    huffman_symbol_packer #(.FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .symbol_in     (symbol_in),
        .symbol_valid  (symbol_valid),
        .symbol_last   (symbol_last),
        .symbol_ready  (symbol_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .byte_count    (byte_count),
        .frame_count   (frame_count),
        .fifo_level    (fifo_level)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [36:0] exp_q[$];
    int          mlane;
    logic [31:0] mpack;
    int          mbytes;
    int          mframes;
    bit          rand_ready = 0;
    bit          hold_valid = 0;
    logic [36:0] hold_entry;
    logic [36:0] mon_e;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        mlane   = 0;
        mpack   = '0;
        mbytes  = 0;
        mframes = 0;
    endtask

    task automatic model_accept(input logic [7:0] b, input logic last);
        logic [3:0] k;
        mpack[mlane*8 +: 8] = b;
        mbytes++;
        if (last) mframes++;
        if (mlane == 3 || last) begin
            k = 4'((1 << (mlane + 1)) - 1);
            exp_q.push_back({mpack, k, last});
            mlane = 0;
            mpack = '0;
        end else begin
            mlane++;
        end
    endtask

    task automatic cycle_sym(input logic v, input logic [7:0] b,
                             input logic last, output bit acc);
        symbol_valid = v;
        symbol_in    = b;
        symbol_last  = last;
        if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
        @(negedge clock);
        acc = v && symbol_ready;
        if (acc) model_accept(b, last);
        @(posedge clock);
        #1;
        symbol_valid = 1'b0;
        symbol_last  = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        bit acc;
        acc = 0;
        for (int t = 0; t < 300 && !acc; t++) cycle_sym(1'b1, b, last, acc);
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        m_axis_tready = 1'b1;
        for (int t = 0; t < 100 && fifo_level != 0; t++) begin
            @(posedge clock);
            #1;
        end
        check("drain_level", fifo_level, 0);
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (hold_valid) begin
                check("hold_valid", m_axis_tvalid, 1);
                check("hold_entry", {m_axis_tdata, m_axis_tkeep, m_axis_tlast},
                      hold_entry);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pop_entry",
                          {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, mon_e);
                end
            end
            hold_valid = m_axis_tvalid && !m_axis_tready;
            hold_entry = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        end else begin
            hold_valid = 0;
        end
    end

    initial begin
        bit acc;
        int n;
        int cyc;
        int max_level;
        logic [7:0] b;

        reset_n       = 1'b0;
        symbol_in     = '0;
        symbol_valid  = 1'b0;
        symbol_last   = 1'b0;
        m_axis_tready = 1'b0;
        model_clear();
        repeat (3) @(posedge clock);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tkeep", m_axis_tkeep, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_bytes", byte_count, 0);
        check("rst_frames", frame_count, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", symbol_ready, 0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("ready_after_rst", symbol_ready, 1);

        // full word, one-cycle latency to tvalid
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        check("w1_tvalid", m_axis_tvalid, 1);
        check("w1_tdata", m_axis_tdata, 32'h44332211);
        check("w1_tkeep", m_axis_tkeep, 4'hF);
        check("w1_tlast", m_axis_tlast, 0);
        check("w1_bytes", byte_count, 4);
        check("w1_level", fifo_level, 1);

        // partial final word
        send(8'hAA, 0); send(8'hBB, 1);
        check("w2_frames", frame_count, 1);
        check("w2_bytes", byte_count, 6);
        check("w2_level", fifo_level, 2);
        m_axis_tready = 1'b1;
        @(posedge clock);
        #1;
        check("w2_tdata", m_axis_tdata, 32'h0000BBAA);
        check("w2_tkeep", m_axis_tkeep, 4'h3);
        check("w2_tlast", m_axis_tlast, 1);
        drain();

        // last flag without valid is ignored
        for (int i = 0; i < 3; i++) cycle_sym(1'b0, 8'h55, 1'b1, acc);
        check("idle_frames", frame_count, 1);
        check("idle_bytes", byte_count, 6);
        check("idle_level", fifo_level, 0);

        // last on lane 3
        m_axis_tready = 1'b0;
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
        check("l3_tdata", m_axis_tdata, 32'h04030201);
        check("l3_tkeep", m_axis_tkeep, 4'hF);
        check("l3_tlast", m_axis_tlast, 1);
        check("l3_frames", frame_count, 2);
        drain();

        // fill until full with tready low
        m_axis_tready = 1'b0;
        n = 0;
        for (int t = 0; t < 200 && n < 4 * DEPTH; t++) begin
            cycle_sym(1'b1, 8'(n), 1'b0, acc);
            if (acc) n++;
        end
        check("fill_count", n, 4 * DEPTH);
        check("full_level", fifo_level, DEPTH);
        check("full_ready", symbol_ready, 0);
        cycle_sym(1'b1, 8'hEE, 1'b0, acc);
        check("full_reject", acc, 0);

        // full FIFO with continuous push and pop
        m_axis_tready = 1'b1;
        n = 0;
        cyc = 0;
        max_level = 0;
        while (n < 4 * DEPTH && cyc < 300) begin
            cycle_sym(1'b1, 8'(8'h80 + n), 1'b0, acc);
            cyc++;
            if (acc) n++;
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
        check("stream_count", n, 4 * DEPTH);
        check("stream_rate", cyc <= 4 * DEPTH + 4, 1);
        check("stream_maxlvl", max_level <= DEPTH, 1);
        drain();
        check("drain_ready", symbol_ready, 1);

        // reset in the middle of a frame
        m_axis_tready = 1'b0;
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        send(8'h05, 0); send(8'h06, 0);
        reset_n = 1'b0;
        model_clear();
        #1;
        check("mid_tvalid", m_axis_tvalid, 0);
        check("mid_bytes", byte_count, 0);
        check("mid_frames", frame_count, 0);
        check("mid_level", fifo_level, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 0);
        check("fresh_tdata", m_axis_tdata, 32'hA4A3A2A1);
        check("fresh_tkeep", m_axis_tkeep, 4'hF);
        check("fresh_bytes", byte_count, 4);
        drain();

        // random frames with random tready
        rand_ready = 1;
        for (int i = 0; i < 1000; i++) begin
            b = 8'($urandom_range(0, 255));
            send(b, 1'($urandom_range(0, 6) == 0));
        end
        rand_ready = 0;
        send(8'h5A, 1);
        drain();
        check("rand_bytes", byte_count, 32'(mbytes));
        check("rand_frames", frame_count, 16'(mframes));
        check("rand_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
